passcode_checker: RTL and testbench
===================================

// Module: passcode_checker
// PURPOSE
//   Consumes the keypad decoder's (digit, valid) stream and checks entered digits against a stored passcode.
//   Emits a one-cycle unlock or fail pulse per completed entry.
//   Enforces a timed lockout after repeated failures.
//   Sits between the keypad decoder and the lock actuator / status display of the security device.
// PARAMETERS
//   CODE_LEN        4         number of digits per entry (1..8)
//   CODE            16'h1234  passcode, 4 bits/digit; first digit = CODE[4*CODE_LEN-1 -: 4]
//   MAX_ATTEMPTS    3         consecutive failures that trigger lockout (>=1)
//   LOCKOUT_CYCLES  1000      clk cycles locked stays high (>=1)
//   TIMEOUT_CYCLES  5000      idle cycles before a partial entry is discarded (macro-gated)
// PORTS
//   clk          in   1                      system clock, all logic on rising edge
//   reset        in   1                      synchronous, active-high
//   digit        in   4                      key code from decoder; sampled only when valid=1
//   valid        in   1                      one-cycle strobe: digit is a new keypress
//   unlock       out  1                      one-cycle pulse: entry matched CODE
//   fail         out  1                      one-cycle pulse: entry mismatched
//   locked       out  1                      high during lockout; all keypresses ignored
//   entry_count  out  $clog2(CODE_LEN+1)     digits accepted in current entry
//   fail_count   out  $clog2(MAX_ATTEMPTS+1) consecutive failures so far
// BEHAVIOUR
//   - Reset (sync, priority over everything): state=ENTRY.
//     Outputs unlock=0, fail=0, locked=0, entry_count=0, fail_count=0.
//     Entry shift register cleared; lockout/timeout counters cleared.
//     Reset mid-entry or mid-lockout abandons that activity.
//   - Key codes: 0x0-0x9 = digit; 0xF = clear; 0xA-0xE ignored (no state change, no timeout restart).
//   - States:
//     - ENTRY:
//       - valid & digit<=9: shift digit into entry reg; entry_count++.
//       - If this makes entry_count==CODE_LEN, go to CHECK on the next edge.
//       - valid & 0xF: entry_count=0, reg cleared; fail_count unchanged. No-op if already empty.
//     - CHECK (exactly 1 cycle): compare entry reg to CODE[4*CODE_LEN-1:0]; valid ignored.
//       - match: unlock=1 this cycle, fail_count=0, entry cleared, -> ENTRY.
//       - mismatch: fail=1 this cycle, fail_count++, entry cleared.
//         If fail_count reaches MAX_ATTEMPTS -> LOCKOUT, else -> ENTRY.
//     - LOCKOUT: locked=1 for exactly LOCKOUT_CYCLES cycles, starting the cycle after the fail pulse.
//       valid ignored. On expiry: locked=0, fail_count=0, -> ENTRY.
//   - Latency: last-digit valid at edge N -> unlock/fail high in cycle N+1 -> entry_count=0 by N+2.
//   - unlock and fail are never high together; each is high for at most one cycle per entry.
//   - valid in the CHECK cycle is dropped (decoder strobes are >=2 cycles apart in practice).
//   - Counters saturate: fail_count never exceeds MAX_ATTEMPTS; entry_count never exceeds CODE_LEN.
//   - Registered outputs only; no combinational path from digit/valid to any output.
// CONFIGURATION
//   INACTIVITY_TIMEOUT_EN defined:
//     - In ENTRY with entry_count>0, an idle counter runs.
//     - Idle counter restarts on every accepted digit or clear.
//     - After TIMEOUT_CYCLES cycles with no valid digit/clear, entry is discarded (entry_count=0).
//     - Discard does not pulse fail and does not count as a failure.
//   INACTIVITY_TIMEOUT_EN undefined:
//     - No idle counter is built; a partial entry persists indefinitely until clear or completion.
//     - TIMEOUT_CYCLES is unused.
// TESTING (CODE=16'h1234, CODE_LEN=4, MAX_ATTEMPTS=3, LOCKOUT_CYCLES=100, TIMEOUT_CYCLES=50)
//   1. Correct code: 1,2,3,4 strobes 4 cycles apart -> unlock=1 for 1 cycle after digit 4.
//      fail stays 0; entry_count returns to 0.
//   2. Clear: 1,2,0xF,1,2,3,4 -> single unlock after final 4; fail_count=0.
//      0xB strobe mid-entry -> entry_count unchanged.
//   3. Lockout: three entries of 9,9,9,9 -> fail pulses with fail_count 1,2,3.
//      locked=1 for exactly 100 cycles; 1,2,3,4 sent during lockout ignored (no unlock).
//      After expiry, 1,2,3,4 -> unlock.
//   4. Failure recovery: 9,9,9,9 then 1,2,3,4 -> fail then unlock, fail_count back to 0.
//      Valid asserted in the CHECK cycle -> dropped.
//   5. Reset: assert reset after 1,2 (entry_count=2) -> next cycle all outputs 0.
//      3,4 alone does not unlock; full 1,2,3,4 does.
//   6. INACTIVITY_TIMEOUT_EN: 1,2 then idle 50 cycles -> entry_count=0, no fail pulse.
//      Then 3,4 gives entry_count=2 and no unlock.
//      Macro undefined: same stimulus -> entry_count=2 persists; 3,4 then unlocks.

Source files
------------

// File: rtl/passcode_checker.sv
`default_nettype none
// ============================================================================
// Module   : passcode_checker
// Checks keypad digit entries against a stored code and locks out after
// repeated failures. Optional macro INACTIVITY_TIMEOUT_EN discards stale entries.
// Revision : 1.0
// ============================================================================
module passcode_checker #(
    parameter int          CODE_LEN       = 4,
    parameter logic [31:0] CODE           = 32'h0000_1234,
    parameter int          MAX_ATTEMPTS   = 3,
    parameter int          LOCKOUT_CYCLES = 1000
`ifdef INACTIVITY_TIMEOUT_EN
   ,parameter int          TIMEOUT_CYCLES = 5000
`endif
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [3:0]                        digit,
    input  logic                              valid,
    output logic                              unlock,
    output logic                              fail,
    output logic                              locked,
    output logic [$clog2(CODE_LEN+1)-1:0]     entry_count,
    output logic [$clog2(MAX_ATTEMPTS+1)-1:0] fail_count
);

    localparam int EW = $clog2(CODE_LEN + 1);
    localparam int FW = $clog2(MAX_ATTEMPTS + 1);
    localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
    localparam int DW = 4 * CODE_LEN;

    localparam logic [EW-1:0] LAST_IDX  = EW'(CODE_LEN - 1);
    localparam logic [FW-1:0] MAX_FAILS = FW'(MAX_ATTEMPTS);
    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCKOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_ENTRY   = 2'd0,
        ST_CHECK   = 2'd1,
        ST_LOCKOUT = 2'd2
    } state_t;

    state_t        state;
    logic [DW-1:0] entry_reg;
    logic [LW-1:0] lock_cnt;

`ifdef INACTIVITY_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] idle_cnt;
`endif

    logic [DW+3:0] shifted;
    logic          is_digit;
    logic          is_clear;
    logic          code_match;
    logic [FW-1:0] fail_inc;

    // The top nibble of shifted is always zero when the final digit arrives
    // (only CODE_LEN-1 digits have been shifted into a cleared register), so
    // comparing the full vector is equivalent to comparing the low DW bits.
    always_comb begin
        shifted    = {entry_reg, digit};
        is_digit   = valid && (digit <= 4'd9);
        is_clear   = valid && (digit == 4'hF);
        code_match = (shifted == {4'h0, CODE[DW-1:0]});
        fail_inc   = (fail_count == MAX_FAILS) ? fail_count : fail_count + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_ENTRY;
            entry_reg   <= '0;
            entry_count <= '0;
            fail_count  <= '0;
            lock_cnt    <= '0;
            unlock      <= 1'b0;
            fail        <= 1'b0;
            locked      <= 1'b0;
`ifdef INACTIVITY_TIMEOUT_EN
            idle_cnt    <= '0;
`endif
        end else begin
            unlock <= 1'b0;
            fail   <= 1'b0;
            case (state)
                ST_ENTRY: begin
                    if (is_digit) begin
                        entry_reg   <= shifted[DW-1:0];
                        entry_count <= entry_count + 1'b1;
`ifdef INACTIVITY_TIMEOUT_EN
                        idle_cnt    <= '0;
`endif
                        // Verdict is registered here so the pulse is visible
                        // during the single CHECK cycle that follows.
                        if (entry_count == LAST_IDX) begin
                            state <= ST_CHECK;
                            if (code_match) begin
                                unlock     <= 1'b1;
                                fail_count <= '0;
                            end else begin
                                fail       <= 1'b1;
                                fail_count <= fail_inc;
                            end
                        end
                    end else if (is_clear) begin
                        entry_reg   <= '0;
                        entry_count <= '0;
`ifdef INACTIVITY_TIMEOUT_EN
                        idle_cnt    <= '0;
`endif
                    end
`ifdef INACTIVITY_TIMEOUT_EN
                    else if (entry_count != '0) begin
                        if (idle_cnt == IDLE_LAST) begin
                            entry_reg   <= '0;
                            entry_count <= '0;
                            idle_cnt    <= '0;
                        end else begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                    end
`endif
                end
                ST_CHECK: begin
                    entry_reg   <= '0;
                    entry_count <= '0;
                    if (fail && (fail_count == MAX_FAILS)) begin
                        state    <= ST_LOCKOUT;
                        locked   <= 1'b1;
                        lock_cnt <= LOCK_LAST;
                    end else begin
                        state <= ST_ENTRY;
                    end
                end
                ST_LOCKOUT: begin
                    if (lock_cnt == '0) begin
                        locked     <= 1'b0;
                        fail_count <= '0;
                        state      <= ST_ENTRY;
                    end else begin
                        lock_cnt <= lock_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= ST_ENTRY;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_passcode_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_passcode_checker
// Scoreboard bench for passcode_checker; pulses are matched against a queue.
// Revision : 1.0
// ============================================================================
module tb_passcode_checker;

    localparam int CODE_LEN       = 4;
    localparam int MAX_ATTEMPTS   = 3;
    localparam int LOCKOUT_CYCLES = 100;
    localparam int TIMEOUT_CYCLES = 50;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] digit;
    logic       valid;
    logic       unlock;
    logic       fail;
    logic       locked;
    logic [2:0] entry_count;
    logic [1:0] fail_count;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic       is_unlock;
        logic [1:0] fc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    passcode_checker #(
        .CODE_LEN       (CODE_LEN),
        .CODE           (32'h0000_1234),
        .MAX_ATTEMPTS   (MAX_ATTEMPTS),
        .LOCKOUT_CYCLES (LOCKOUT_CYCLES)
`ifdef INACTIVITY_TIMEOUT_EN
       ,.TIMEOUT_CYCLES (TIMEOUT_CYCLES)
`endif
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .digit       (digit),
        .valid       (valid),
        .unlock      (unlock),
        .fail        (fail),
        .locked      (locked),
        .entry_count (entry_count),
        .fail_count  (fail_count)
    );

    always #5 clk = ~clk;

    // Every unlock/fail pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!reset && (unlock || fail)) begin
            checks++;
            if (unlock && fail) begin
                errors++;
                $display("FAIL both_pulses: unlock=%b fail=%b, required at most one high", unlock, fail);
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: unlock=%b fail=%b fail_count=%0d, required no pulse",
                         unlock, fail, fail_count);
            end else begin
                mon_e = exp_q.pop_front();
                if (unlock !== mon_e.is_unlock || fail_count !== mon_e.fc) begin
                    errors++;
                    $display("FAIL pulse_kind: unlock=%b fail_count=%0d, required unlock=%b fail_count=%0d",
                             unlock, fail_count, mon_e.is_unlock, mon_e.fc);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic press(input logic [3:0] d);
        @(negedge clk);
        digit = d;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic enter_code(input logic [15:0] c);
        for (int i = 0; i < 4; i++) press(c[15-4*i -: 4]);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        valid = 1'b0;
        digit = 4'h0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({unlock, fail, locked, entry_count, fail_count} !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: outputs=%b, required all zero",
                     {unlock, fail, locked, entry_count, fail_count});
        end
    endtask

    task automatic test_correct_code;
        exp_q.push_back({1'b1, 2'd0});
        enter_code(16'h1234);
        checks++;
        if (entry_count !== 3'd0) begin
            errors++;
            $display("FAIL correct_entry_count: got %0d, required 0", entry_count);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL correct_pending: %0d pulses missing, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_clear;
        press(4'h1);
        press(4'h2);
        press(4'hB);
        checks++;
        if (entry_count !== 3'd2) begin
            errors++;
            $display("FAIL ignored_key_count: got %0d, required 2", entry_count);
        end
        press(4'hF);
        checks++;
        if (entry_count !== 3'd0) begin
            errors++;
            $display("FAIL clear_count: got %0d, required 0", entry_count);
        end
        press(4'hF);
        checks++;
        if (entry_count !== 3'd0 || fail_count !== 2'd0) begin
            errors++;
            $display("FAIL clear_empty: entry_count=%0d fail_count=%0d, required 0 0", entry_count, fail_count);
        end
        exp_q.push_back({1'b1, 2'd0});
        enter_code(16'h1234);
        checks++;
        if (fail_count !== 2'd0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL clear_unlock: fail_count=%0d pending=%0d, required 0 0", fail_count, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_lockout;
        int n_locked;
        int first_hi;
        exp_q.push_back({1'b0, 2'd1});
        enter_code(16'h9999);
        checks++;
        if (fail_count !== 2'd1 || locked !== 1'b0) begin
            errors++;
            $display("FAIL lock_first_fail: fail_count=%0d locked=%b, required 1 0", fail_count, locked);
        end
        exp_q.push_back({1'b0, 2'd2});
        enter_code(16'h9999);
        exp_q.push_back({1'b0, 2'd3});
        press(4'h9);
        press(4'h9);
        press(4'h9);
        @(negedge clk);
        digit = 4'h9;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL lock_early: locked=%b during fail pulse, required 0", locked);
        end
        n_locked = 0;
        first_hi = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (locked) begin
                n_locked++;
                if (first_hi < 0) first_hi = i;
            end
            if (i == 50) begin
                checks++;
                if (fail_count !== 2'd3) begin
                    errors++;
                    $display("FAIL lock_fail_count: got %0d, required 3", fail_count);
                end
            end
            if (i == 10 || i == 14 || i == 18 || i == 22) begin
                digit = 4'(1 + (i - 10) / 4);
                valid = 1'b1;
            end else begin
                valid = 1'b0;
            end
        end
        checks++;
        if (n_locked != LOCKOUT_CYCLES || first_hi != 0) begin
            errors++;
            $display("FAIL lock_duration: cycles=%0d start=%0d, required %0d 0", n_locked, first_hi, LOCKOUT_CYCLES);
        end
        checks++;
        if (fail_count !== 2'd0 || entry_count !== 3'd0 || locked !== 1'b0) begin
            errors++;
            $display("FAIL lock_expiry: fail_count=%0d entry_count=%0d locked=%b, required 0 0 0",
                     fail_count, entry_count, locked);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL lock_pending: %0d pulses missing, required 0", exp_q.size());
            exp_q.delete();
        end
        exp_q.push_back({1'b1, 2'd0});
        enter_code(16'h1234);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL lock_recover_unlock: %0d pulses missing, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_recovery;
        exp_q.push_back({1'b0, 2'd1});
        enter_code(16'h9999);
        checks++;
        if (fail_count !== 2'd1) begin
            errors++;
            $display("FAIL recov_fail_count: got %0d, required 1", fail_count);
        end
        exp_q.push_back({1'b1, 2'd0});
        press(4'h1);
        press(4'h2);
        press(4'h3);
        @(negedge clk);
        digit = 4'h4;
        valid = 1'b1;
        @(negedge clk);
        digit = 4'h5;
        @(negedge clk);
        valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (entry_count !== 3'd0) begin
            errors++;
            $display("FAIL check_cycle_drop: entry_count=%0d, required 0", entry_count);
        end
        checks++;
        if (fail_count !== 2'd0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL recov_unlock: fail_count=%0d pending=%0d, required 0 0", fail_count, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset_mid_entry;
        press(4'h1);
        press(4'h2);
        checks++;
        if (entry_count !== 3'd2) begin
            errors++;
            $display("FAIL pre_reset_count: got %0d, required 2", entry_count);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({unlock, fail, locked, entry_count, fail_count} !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset_state: outputs=%b, required all zero",
                     {unlock, fail, locked, entry_count, fail_count});
        end
        press(4'h3);
        press(4'h4);
        checks++;
        if (entry_count !== 3'd2) begin
            errors++;
            $display("FAIL post_reset_partial: entry_count=%0d, required 2", entry_count);
        end
        press(4'hF);
        exp_q.push_back({1'b1, 2'd0});
        enter_code(16'h1234);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL post_reset_unlock: %0d pulses missing, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_timeout;
        press(4'h1);
        @(negedge clk);
        digit = 4'h2;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        repeat (49) @(negedge clk);
        checks++;
        if (entry_count !== 3'd2) begin
            errors++;
            $display("FAIL idle_before_limit: entry_count=%0d, required 2", entry_count);
        end
        @(negedge clk);
`ifdef INACTIVITY_TIMEOUT_EN
        checks++;
        if (entry_count !== 3'd0) begin
            errors++;
            $display("FAIL idle_discard: entry_count=%0d, required 0", entry_count);
        end
        press(4'h3);
        press(4'h4);
        checks++;
        if (entry_count !== 3'd2 || fail_count !== 2'd0) begin
            errors++;
            $display("FAIL idle_restart: entry_count=%0d fail_count=%0d, required 2 0", entry_count, fail_count);
        end
        press(4'hF);
`else
        checks++;
        if (entry_count !== 3'd2) begin
            errors++;
            $display("FAIL idle_persist: entry_count=%0d, required 2", entry_count);
        end
        exp_q.push_back({1'b1, 2'd0});
        press(4'h3);
        press(4'h4);
        checks++;
        if (entry_count !== 3'd0) begin
            errors++;
            $display("FAIL idle_complete: entry_count=%0d, required 0", entry_count);
        end
`endif
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL idle_pending: %0d pulses missing, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        reset = 1'b1;
        valid = 1'b0;
        digit = 4'h0;
        test_reset();
        test_correct_code();
        test_clear();
        test_lockout();
        test_recovery();
        test_reset_mid_entry();
        test_timeout();
        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
